// File: rtl/m92_pkg.sv
// Shared M92 main-CPU I/O constants and small helpers for the sound mailbox.
package m92_pkg;

  // Main-CPU I/O ports owned by the sound mailbox.
  localparam logic [7:0] IO_SOUNDLATCH  = 8'h00;
  localparam logic [7:0] IO_SOUNDLATCH2 = 8'h08;

  // Value driven on a read bus when nothing valid is presented.
  localparam logic [7:0] BUS_IDLE = 8'hff;

  // Effective FIFO operation in one cycle, after full/empty qualification.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Encode qualified push/pop into a single operation code.
  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    fifo_op_e op;
    case ({push, pop})
      2'b01:   op = FIFO_POP;
      2'b10:   op = FIFO_PUSH;
      2'b11:   op = FIFO_BOTH;
      default: op = FIFO_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Command FIFO from the main CPU to the sound CPU: storage, pointers,
// occupancy, and a sticky overrun flag. flush_i acts as a synchronous clear.
module sound_cmd_fifo
  import m92_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [7:0]                 data_i,
  output logic [7:0]                 head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       overrun_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          full_s;
  logic          do_pop_s;
  logic          do_push_s;
  fifo_op_e      op_s;

  // Qualify requests: a pop needs data, a push needs a slot (a same-cycle pop frees one).
  always_comb begin
    empty_o   = (count_q == CW'(0));
    full_s    = (count_q == CW'(DEPTH));
    do_pop_s  = pop_i & ~empty_o & ~flush_i;
    do_push_s = push_i & (~full_s | do_pop_s) & ~flush_i;
    op_s      = fifo_op(do_push_s, do_pop_s);
  end

  // Next-state for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      case (op_s)
        FIFO_PUSH: begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          count_d  = count_q + CW'(1);
        end
        FIFO_POP: begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
        end
        FIFO_BOTH: begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        default: begin
          count_d = count_q;
        end
      endcase
      if (push_i && !do_push_s) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Head of queue is presented combinationally; idle bus value when empty.
  always_comb begin
    if (empty_o) begin
      head_o = BUS_IDLE;
    end else begin
      head_o = mem_q[rd_ptr_q];
    end
  end

  assign count_o   = count_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/m92_sound_latch.sv
// Main-CPU / sound-CPU mailbox: command FIFO toward the sound CPU, reply
// latch toward the main CPU, strobe edge detection and both level IRQs.
module m92_sound_latch
  import m92_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK_32M,
  input  logic                   reset_n,
  input  logic                   main_io_wr,
  input  logic                   main_io_rd,
  input  logic [7:0]             main_io_addr,
  input  logic [7:0]             main_io_din,
  output logic [7:0]             main_io_dout,
  output logic                   main_irq,
  input  logic                   snd_reset_n,
  input  logic                   snd_cmd_rd,
  output logic [7:0]             snd_cmd_dout,
  input  logic                   snd_reply_wr,
  input  logic [7:0]             snd_din,
  output logic                   snd_irq,
  output logic                   snd_overrun,
  output logic [$clog2(DEPTH):0] cmd_count
);

  logic       wr_prev_q, rd_prev_q, cmd_rd_prev_q, reply_wr_prev_q;
  logic [7:0] reply_q, reply_d;
  logic       main_irq_q, main_irq_d;
  logic       push_s, pop_s, reply_ld_s, reply_ack_s, flush_s;
  logic       fifo_empty_s;

  // Previous strobe levels, so that multi-cycle strobes act only once.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q       <= 1'b0;
      rd_prev_q       <= 1'b0;
      cmd_rd_prev_q   <= 1'b0;
      reply_wr_prev_q <= 1'b0;
    end else begin
      wr_prev_q       <= main_io_wr;
      rd_prev_q       <= main_io_rd;
      cmd_rd_prev_q   <= snd_cmd_rd;
      reply_wr_prev_q <= snd_reply_wr;
    end
  end

  // Rising-edge qualification and address decode; sound-side strobes are
  // ignored while the sound CPU is held in reset.
  always_comb begin
    flush_s     = ~snd_reset_n;
    push_s      = main_io_wr & ~wr_prev_q & (main_io_addr == IO_SOUNDLATCH);
    reply_ack_s = main_io_rd & ~rd_prev_q & (main_io_addr == IO_SOUNDLATCH2);
    pop_s       = snd_cmd_rd & ~cmd_rd_prev_q & snd_reset_n;
    reply_ld_s  = snd_reply_wr & ~reply_wr_prev_q & snd_reset_n;
  end

  // Reply latch and main IRQ: a reply write beats a same-cycle acknowledge.
  always_comb begin
    reply_d    = reply_q;
    main_irq_d = main_irq_q;
    if (reply_ld_s) begin
      reply_d    = snd_din;
      main_irq_d = 1'b1;
    end else if (reply_ack_s) begin
      main_irq_d = 1'b0;
    end else begin
      main_irq_d = main_irq_q;
    end
  end

  // Reply state registers; unaffected by the sound-CPU reset.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      reply_q    <= 8'h00;
      main_irq_q <= 1'b0;
    end else begin
      reply_q    <= reply_d;
      main_irq_q <= main_irq_d;
    end
  end

  // Main-side read mux: only the reply port returns data.
  always_comb begin
    if (main_io_addr == IO_SOUNDLATCH2) begin
      main_io_dout = reply_q;
    end else begin
      main_io_dout = BUS_IDLE;
    end
  end

  sound_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (CLK_32M),
    .reset_n_i (reset_n),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .flush_i   (flush_s),
    .data_i    (main_io_din),
    .head_o    (snd_cmd_dout),
    .count_o   (cmd_count),
    .empty_o   (fifo_empty_s),
    .overrun_o (snd_overrun)
  );

  assign snd_irq  = ~fifo_empty_s;
  assign main_irq = main_irq_q;

endmodule

// File: tb/tb_m92_sound_latch.sv
// Directed bench for m92_sound_latch with a command scoreboard queue.
module tb_m92_sound_latch;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK_32M = 1'b0;
  logic          reset_n;
  logic          main_io_wr, main_io_rd;
  logic [7:0]    main_io_addr, main_io_din;
  logic [7:0]    main_io_dout;
  logic          main_irq;
  logic          snd_reset_n, snd_cmd_rd, snd_reply_wr;
  logic [7:0]    snd_cmd_dout, snd_din;
  logic          snd_irq, snd_overrun;
  logic [CW-1:0] cmd_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  m92_sound_latch #(.DEPTH(DEPTH)) dut (
    .CLK_32M      (CLK_32M),
    .reset_n      (reset_n),
    .main_io_wr   (main_io_wr),
    .main_io_rd   (main_io_rd),
    .main_io_addr (main_io_addr),
    .main_io_din  (main_io_din),
    .main_io_dout (main_io_dout),
    .main_irq     (main_irq),
    .snd_reset_n  (snd_reset_n),
    .snd_cmd_rd   (snd_cmd_rd),
    .snd_cmd_dout (snd_cmd_dout),
    .snd_reply_wr (snd_reply_wr),
    .snd_din      (snd_din),
    .snd_irq      (snd_irq),
    .snd_overrun  (snd_overrun),
    .cmd_count    (cmd_count)
  );

  always #5 CLK_32M = ~CLK_32M;

  task automatic tick();
    @(posedge CLK_32M);
    @(negedge CLK_32M);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Single-cycle main write; model accepts the command only if a slot is free.
  task automatic push_cmd(input logic [7:0] addr, input logic [7:0] d, input bit stored);
    main_io_addr = addr;
    main_io_din  = d;
    main_io_wr   = 1'b1;
    tick();
    main_io_wr   = 1'b0;
    tick();
    if (stored && addr == 8'h00 && exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  // Compare the presented head against the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hff;
    check(tag, {24'h0, snd_cmd_dout}, {24'h0, e});
    snd_cmd_rd = 1'b1;
    tick();
    snd_cmd_rd = 1'b0;
    tick();
  endtask

  task automatic main_read08();
    main_io_addr = 8'h08;
    main_io_rd   = 1'b1;
    tick();
    main_io_rd   = 1'b0;
    tick();
  endtask

  task automatic reply_write(input logic [7:0] d);
    snd_din      = d;
    snd_reply_wr = 1'b1;
    tick();
    snd_reply_wr = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; snd_reset_n = 1'b1;
    main_io_wr = 1'b0; main_io_rd = 1'b0; main_io_addr = 8'h08; main_io_din = 8'h00;
    snd_cmd_rd = 1'b0; snd_reply_wr = 1'b0; snd_din = 8'h00;
    tick(); tick();
    check("rst_count",   32'(cmd_count), 32'd0);
    check("rst_snd_irq", 32'(snd_irq), 32'd0);
    check("rst_overrun", 32'(snd_overrun), 32'd0);
    check("rst_main_irq", 32'(main_irq), 32'd0);
    check("rst_cmd_dout", 32'(snd_cmd_dout), 32'hff);
    check("rst_reply",   32'(main_io_dout), 32'h00);
    reset_n = 1'b1;
    tick();

    // 2-cycle write strobe: exactly one push, visible one cycle after the edge.
    main_io_addr = 8'h00; main_io_din = 8'h5a; main_io_wr = 1'b1;
    tick();
    check("t1_count_1",  32'(cmd_count), 32'd1);
    check("t1_irq",      32'(snd_irq), 32'd1);
    check("t1_dout",     32'(snd_cmd_dout), 32'h5a);
    tick();
    main_io_wr = 1'b0;
    tick();
    check("t1_count_2cyc", 32'(cmd_count), 32'd1);
    exp_q.push_back(8'h5a);
    pop_check("t1_pop");
    check("t1_empty_irq", 32'(snd_irq), 32'd0);

    // Writes to other ports are ignored.
    push_cmd(8'h05, 8'hee, 1'b0);
    push_cmd(8'h08, 8'hee, 1'b0);
    check("addr_ignore", 32'(cmd_count), 32'd0);

    // Overfill: fifth push is dropped and flagged.
    for (int i = 1; i <= 5; i++) push_cmd(8'h00, 8'(i), 1'b1);
    check("t2_count",   32'(cmd_count), 32'd4);
    check("t2_overrun", 32'(snd_overrun), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("t2_pop");
    check("t2_dout_ff", 32'(snd_cmd_dout), 32'hff);
    check("t2_irq",     32'(snd_irq), 32'd0);
    check("t2_count0",  32'(cmd_count), 32'd0);
    pop_check("t2_pop_empty");
    check("t2_pop_empty_cnt", 32'(cmd_count), 32'd0);

    // Clear the sticky overrun via a one-cycle sound reset.
    snd_reset_n = 1'b0; tick(); snd_reset_n = 1'b1; tick();
    check("ovr_clear", 32'(snd_overrun), 32'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) push_cmd(8'h00, 8'(8'h10 + i), 1'b1);
    check("t3_full", 32'(cmd_count), 32'd4);
    check("t3_head", 32'(snd_cmd_dout), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h77);
    main_io_addr = 8'h00; main_io_din = 8'h77; main_io_wr = 1'b1; snd_cmd_rd = 1'b1;
    tick();
    main_io_wr = 1'b0; snd_cmd_rd = 1'b0;
    tick();
    check("t3_count",   32'(cmd_count), 32'd4);
    check("t3_overrun", 32'(snd_overrun), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("t3_pop");
    check("t3_count0", 32'(cmd_count), 32'd0);

    // Empty FIFO with simultaneous push and pop: push wins.
    exp_q.push_back(8'h3c);
    main_io_addr = 8'h00; main_io_din = 8'h3c; main_io_wr = 1'b1; snd_cmd_rd = 1'b1;
    tick();
    main_io_wr = 1'b0; snd_cmd_rd = 1'b0;
    tick();
    check("emp_both_cnt", 32'(cmd_count), 32'd1);
    pop_check("emp_both_pop");

    // Reply path.
    reply_write(8'hc3);
    check("t4_irq", 32'(main_irq), 32'd1);
    main_io_addr = 8'h08; #1;
    check("t4_rd08", 32'(main_io_dout), 32'hc3);
    main_io_addr = 8'h09; #1;
    check("t4_rd09", 32'(main_io_dout), 32'hff);
    main_read08();
    check("t4_irq_clr", 32'(main_irq), 32'd0);

    // Reply write and acknowledge in the same cycle: write wins.
    reply_write(8'h22);
    main_io_addr = 8'h08; main_io_rd = 1'b1; snd_din = 8'h11; snd_reply_wr = 1'b1;
    tick();
    main_io_rd = 1'b0; snd_reply_wr = 1'b0;
    tick();
    check("t5_irq",  32'(main_irq), 32'd1);
    check("t5_data", 32'(main_io_dout), 32'h11);

    // Sound-CPU reset: flush commands, keep reply state, drop pushes.
    push_cmd(8'h00, 8'ha1, 1'b1);
    push_cmd(8'h00, 8'ha2, 1'b1);
    reply_write(8'h42);
    check("t6_pre_count", 32'(cmd_count), 32'd2);
    snd_reset_n = 1'b0;
    main_io_addr = 8'h00; main_io_din = 8'hb0; main_io_wr = 1'b1;
    snd_din = 8'h99; snd_reply_wr = 1'b1;
    tick();
    main_io_wr = 1'b0; snd_reply_wr = 1'b0;
    tick();
    tick();
    check("t6_rst_count",   32'(cmd_count), 32'd0);
    check("t6_rst_overrun", 32'(snd_overrun), 32'd0);
    snd_reset_n = 1'b1;
    exp_q.delete();
    tick();
    check("t6_count",    32'(cmd_count), 32'd0);
    check("t6_snd_irq",  32'(snd_irq), 32'd0);
    check("t6_overrun",  32'(snd_overrun), 32'd0);
    check("t6_main_irq", 32'(main_irq), 32'd1);
    main_io_addr = 8'h08; #1;
    check("t6_reply",    32'(main_io_dout), 32'h42);
    check("t6_cmd_dout", 32'(snd_cmd_dout), 32'hff);
    push_cmd(8'h00, 8'hc5, 1'b1);
    pop_check("t6_post_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
